// File: rtl/midi_voice_env.sv
// Per-voice ADSR envelope: detects note-on/off from held MIDI registers and
// steps a five-state envelope at a fixed tick rate, with velocity-scaled amplitude.
module midi_voice_env #(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned TICK_HZ       = 48_000,
    parameter logic [15:0] ATTACK_STEP   = 16'h0100,
    parameter logic [15:0] DECAY_STEP    = 16'h0040,
    parameter logic [15:0] SUSTAIN_LEVEL = 16'hC000,
    parameter logic [15:0] RELEASE_STEP  = 16'h0020
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic [7:0]  midi_note,
    input  logic [7:0]  velocity,
    output logic [6:0]  note_out,
    output logic        gate,
    output logic [2:0]  env_state,
    output logic [15:0] env_level,
    output logic [15:0] amp_out
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [6:0]       prev_note_q;
    logic [7:0]       prev_vel_q;
    logic [6:0]       vel_lat_q;

    logic [15:0]      level_d;
    logic             gate_d;
    logic [6:0]       note_d;
    logic [6:0]       vel_lat_d;

    logic             tick;
    logic             note_on;
    logic             note_off;
    logic [16:0]      attack_sum;
    logic [16:0]      decay_floor;
    logic             unused_note_msb;

    assign unused_note_msb = midi_note[7];

    assign tick     = (cnt_q == CNT_W'(DIV - 1));
    assign note_on  = (velocity != 8'd0) &&
                      ((prev_vel_q == 8'd0) || (midi_note[6:0] != prev_note_q));
    assign note_off = (velocity == 8'd0) && (prev_vel_q != 8'd0);

    assign attack_sum  = {1'b0, env_level} + {1'b0, ATTACK_STEP};
    assign decay_floor = {1'b0, SUSTAIN_LEVEL} + {1'b0, DECAY_STEP};

    assign env_state = state_q;

    // Next-state and envelope update; events pre-empt a coincident tick.
    always_comb begin
        state_d   = state_q;
        level_d   = env_level;
        gate_d    = gate;
        note_d    = note_out;
        vel_lat_d = vel_lat_q;

        if (note_on) begin
            note_d    = midi_note[6:0];
            vel_lat_d = velocity[6:0];
            gate_d    = 1'b1;
            state_d   = ST_ATTACK;
        end else if (note_off) begin
            gate_d = 1'b0;
            if (state_q == ST_ATTACK || state_q == ST_DECAY || state_q == ST_SUSTAIN) begin
                state_d = ST_RELEASE;
            end
        end else if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    level_d = 16'h0000;
                end
                ST_ATTACK: begin
                    if (attack_sum >= 17'h0FFFF) begin
                        level_d = 16'hFFFF;
                        state_d = ST_DECAY;
                    end else begin
                        level_d = attack_sum[15:0];
                    end
                end
                ST_DECAY: begin
                    if ({1'b0, env_level} <= decay_floor) begin
                        level_d = SUSTAIN_LEVEL;
                        state_d = ST_SUSTAIN;
                    end else begin
                        level_d = env_level - DECAY_STEP;
                    end
                end
                ST_SUSTAIN: begin
                    level_d = env_level;
                end
                ST_RELEASE: begin
                    if (env_level <= RELEASE_STEP) begin
                        level_d = 16'h0000;
                        state_d = ST_IDLE;
                    end else begin
                        level_d = env_level - RELEASE_STEP;
                    end
                end
                default: begin
                    level_d = 16'h0000;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, envelope, event history and tick counter registers.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            prev_note_q <= 7'd0;
            prev_vel_q  <= 8'd0;
            vel_lat_q   <= 7'd0;
            note_out    <= 7'd0;
            gate        <= 1'b0;
            env_level   <= 16'h0000;
            amp_out     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= tick ? '0 : cnt_q + CNT_W'(1);
            prev_note_q <= midi_note[6:0];
            prev_vel_q  <= velocity;
            vel_lat_q   <= vel_lat_d;
            note_out    <= note_d;
            gate        <= gate_d;
            env_level   <= level_d;
            amp_out     <= 16'((23'(env_level) * 23'(vel_lat_q)) >> 7);
        end
    end

endmodule

// File: tb/tb_midi_voice_env.sv
// Bench for midi_voice_env: directed vector table, tick-collision and reset
// sequences, then random key traffic against a behavioural envelope model.
module tb_midi_voice_env;

    localparam int unsigned CLK_HZ  = 100;
    localparam int unsigned TICK_HZ = 10;
    localparam int          DIV     = 10;
    localparam int          ATK     = 'h4000;
    localparam int          DEC     = 'h1000;
    localparam int          SUS     = 'hC000;
    localparam int          REL     = 'h2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  midi_note;
    logic [7:0]  velocity;
    logic [6:0]  note_out;
    logic        gate;
    logic [2:0]  env_state;
    logic [15:0] env_level;
    logic [15:0] amp_out;

    always #5 clk = ~clk;

    midi_voice_env #(
        .CLK_HZ       (CLK_HZ),
        .TICK_HZ      (TICK_HZ),
        .ATTACK_STEP  (16'(ATK)),
        .DECAY_STEP   (16'(DEC)),
        .SUSTAIN_LEVEL(16'(SUS)),
        .RELEASE_STEP (16'(REL))
    ) dut (
        .clk_50m  (clk),
        .rst_n    (rst_n),
        .midi_note(midi_note),
        .velocity (velocity),
        .note_out (note_out),
        .gate     (gate),
        .env_state(env_state),
        .env_level(env_level),
        .amp_out  (amp_out)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    // Behavioural model state
    int m_cnt, m_state, m_level, m_amp, m_vl, m_note, m_pnote, m_pvel;
    bit m_gate;

    always @(posedge clk) begin : model
        bit tk, on, off;
        int new_amp;
        if (!rst_n) begin
            m_cnt = 0; m_state = 0; m_level = 0; m_amp = 0; m_vl = 0;
            m_note = 0; m_pnote = 0; m_pvel = 0; m_gate = 1'b0;
        end else begin
            tk  = (m_cnt == DIV - 1);
            on  = (velocity != 0) && (m_pvel == 0 || int'(midi_note[6:0]) != m_pnote);
            off = (velocity == 0) && (m_pvel != 0);
            new_amp = (m_level * m_vl) / 128;
            if (on) begin
                m_note  = int'(midi_note[6:0]);
                m_vl    = int'(velocity[6:0]);
                m_gate  = 1'b1;
                m_state = 1;
            end else if (off) begin
                m_gate = 1'b0;
                if (m_state >= 1 && m_state <= 3) m_state = 4;
            end else if (tk) begin
                case (m_state)
                    0: m_level = 0;
                    1: if (m_level + ATK >= 65535) begin m_level = 65535; m_state = 2; end
                       else m_level = m_level + ATK;
                    2: if (m_level <= SUS + DEC) begin m_level = SUS; m_state = 3; end
                       else m_level = m_level - DEC;
                    4: if (m_level <= REL) begin m_level = 0; m_state = 0; end
                       else m_level = m_level - REL;
                    default: ;
                endcase
            end
            m_cnt   = tk ? 0 : m_cnt + 1;
            m_pvel  = int'(velocity);
            m_pnote = int'(midi_note[6:0]);
            m_amp   = new_amp;
        end
    end

    task automatic check(input string name, input logic [6:0] en, input logic eg,
                         input logic [2:0] es, input logic [15:0] el, input logic [15:0] ea);
        n_checks++;
        if ({note_out, gate, env_state, env_level, amp_out} !== {en, eg, es, el, ea}) begin
            n_fail++;
            $display("FAIL %s @%0t: got note=%0d gate=%0d state=%0d level=%h amp=%h, expected note=%0d gate=%0d state=%0d level=%h amp=%h",
                     name, $time, note_out, gate, env_state, env_level, amp_out, en, eg, es, el, ea);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) check("model", 7'(m_note), m_gate, 3'(m_state), 16'(m_level), 16'(m_amp));
    end

    // Advance edges until one tick edge has passed (checked at the following negedge).
    task automatic wait_tick();
        bit seen = 1'b0;
        for (int k = 0; k < 4 * DIV && !seen; k++) begin
            seen = (m_cnt == DIV - 1);
            @(negedge clk);
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout @%0t: no tick within %0d cycles", $time, 4 * DIV);
        end
    endtask

    task automatic do_reset(input logic [7:0] n, input logic [7:0] v);
        rst_n = 1'b0; midi_note = n; velocity = v;
        repeat (3) @(negedge clk);
        check("reset_state", 7'd0, 1'b0, 3'd0, 16'h0000, 16'h0000);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0]  note;
        logic [7:0]  vel;
        int          cyc;
        bit          tk;
        logic [6:0]  en;
        logic        eg;
        logic [2:0]  es;
        logic [15:0] el;
        logic [15:0] ea;
    } vec_t;

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{8'd60, 8'd100, 1, 1'b0, 7'd60, 1'b1, 3'd1, 16'h0000, 16'h0000};
        tbl[1]  = '{8'd60, 8'd100, 0, 1'b1, 7'd60, 1'b1, 3'd1, 16'h4000, 16'h0000};
        tbl[2]  = '{8'd60, 8'd100, 0, 1'b1, 7'd60, 1'b1, 3'd1, 16'h8000, 16'h3200};
        tbl[3]  = '{8'd60, 8'd100, 0, 1'b1, 7'd60, 1'b1, 3'd1, 16'hC000, 16'h6400};
        tbl[4]  = '{8'd60, 8'd100, 0, 1'b1, 7'd60, 1'b1, 3'd2, 16'hFFFF, 16'h9600};
        tbl[5]  = '{8'd60, 8'd100, 1, 1'b0, 7'd60, 1'b1, 3'd2, 16'hFFFF, 16'hC7FF};
        tbl[6]  = '{8'd60, 8'd100, 0, 1'b1, 7'd60, 1'b1, 3'd2, 16'hEFFF, 16'hC7FF};
        tbl[7]  = '{8'd60, 8'd100, 0, 1'b1, 7'd60, 1'b1, 3'd2, 16'hDFFF, 16'hBB7F};
        tbl[8]  = '{8'd60, 8'd100, 0, 1'b1, 7'd60, 1'b1, 3'd2, 16'hCFFF, 16'hAEFF};
        tbl[9]  = '{8'd60, 8'd100, 0, 1'b1, 7'd60, 1'b1, 3'd3, 16'hC000, 16'hA27F};
        tbl[10] = '{8'd60, 8'd100, 1, 1'b0, 7'd60, 1'b1, 3'd3, 16'hC000, 16'h9600};
        tbl[11] = '{8'd60, 8'd0,   1, 1'b0, 7'd60, 1'b0, 3'd4, 16'hC000, 16'h9600};
        tbl[12] = '{8'd60, 8'd0,   0, 1'b1, 7'd60, 1'b0, 3'd4, 16'hA000, 16'h9600};
        tbl[13] = '{8'd60, 8'd0,   0, 1'b1, 7'd60, 1'b0, 3'd4, 16'h8000, 16'h7D00};
        tbl[14] = '{8'd60, 8'd0,   0, 1'b1, 7'd60, 1'b0, 3'd4, 16'h6000, 16'h6400};
        tbl[15] = '{8'd64, 8'd100, 1, 1'b0, 7'd64, 1'b1, 3'd1, 16'h6000, 16'h4B00};
        tbl[16] = '{8'd64, 8'd100, 0, 1'b1, 7'd64, 1'b1, 3'd1, 16'hA000, 16'h4B00};

        rst_n = 1'b0; midi_note = 8'd0; velocity = 8'd0;
        @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);

        // Directed ADSR walk through the vector table
        do_reset(8'd0, 8'd0);
        for (int i = 0; i < 17; i++) begin
            midi_note = tbl[i].note;
            velocity  = tbl[i].vel;
            if (tbl[i].tk) wait_tick();
            else repeat (tbl[i].cyc) @(negedge clk);
            check($sformatf("vec%0d", i), tbl[i].en, tbl[i].eg, tbl[i].es, tbl[i].el, tbl[i].ea);
        end

        // Note-off landing on a tick cycle in ATTACK, then reset mid-RELEASE
        do_reset(8'd0, 8'd0);
        midi_note = 8'd60; velocity = 8'd100;
        @(negedge clk);
        wait_tick();
        wait_tick();
        check("attack_8000", 7'd60, 1'b1, 3'd1, 16'h8000, 16'h3200);
        for (int k = 0; k < 2 * DIV && m_cnt != DIV - 1; k++) @(negedge clk);
        velocity = 8'd0;
        @(negedge clk);
        check("off_on_tick", 7'd60, 1'b0, 3'd4, 16'h8000, 16'h6400);
        wait_tick();
        check("release_after_skip", 7'd60, 1'b0, 3'd4, 16'h6000, 16'h6400);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_mid_release", 7'd0, 1'b0, 3'd0, 16'h0000, 16'h0000);
        rst_n = 1'b1;

        // Key held through reset yields a note-on right after release
        do_reset(8'd198, 8'd50);
        @(negedge clk);
        check("held_through_reset", 7'd70, 1'b1, 3'd1, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);

        // Random key traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                midi_note = 8'($urandom);
                velocity  = $urandom_range(0, 1) ? 8'($urandom) : 8'd0;
            end
            rst_n = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
        end

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/midi_voice_env.md
# midi_voice_env

Per-voice ADSR envelope stage that sits directly downstream of the MIDI front end. It consumes one channel's held note/velocity register pair (midi_note_x / velocity_x, where velocity 0 means key released) and detects note-on, note-off and retrigger events from level changes. It runs a five-state attack/decay/sustain/release machine at a fixed update rate and outputs the latched note, a gate, the envelope level and a velocity-scaled amplitude for the oscillator/VCA stage. One instance is used per voice (A, B).

## Interface
- CLK_HZ, 50_000_000: system clock frequency.
- TICK_HZ, 48_000: envelope update rate. DIV = CLK_HZ/TICK_HZ (integer division) must be ≥ 2.
- ATTACK_STEP, 16'h0100: level increment per tick in ATTACK.
- DECAY_STEP, 16'h0040: level decrement per tick in DECAY.
- SUSTAIN_LEVEL, 16'hC000: sustain plateau. Must be less than 16'hFFFF.
- RELEASE_STEP, 16'h0020: level decrement per tick in RELEASE.
- clk_50m  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- midi_note  in  8  held note number from the MIDI front end; bit 7 is ignored.
- velocity  in  8  held velocity; 0 = key up, nonzero = key down.
- note_out  out  7  note latched at the last note-on event.
- gate  out  1  1 from a note-on event until the next note-off event.
- env_state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- env_level  out  16  unsigned envelope level; 16'hFFFF = full scale.
- amp_out  out  16  (env_level × vel_lat) >> 7, registered.

## Operation
- Reset (rst_n low at an edge): all outputs are 0, state is IDLE, vel_lat = 0, prev_note = 0, prev_vel = 0, tick counter = 0.
- Event detection:
  - prev_note and prev_vel are registered copies of the inputs, updated every cycle.
  - note_on = (velocity ≠ 0) && (prev_vel == 0 || midi_note[6:0] ≠ prev_note[6:0]).
  - note_off = (velocity == 0) && (prev_vel ≠ 0).
  - The two events are mutually exclusive by construction.
- On note_on:
  - note_out ← midi_note[6:0]; vel_lat ← velocity[6:0]; gate ← 1.
  - State ← ATTACK from any state. env_level is retained (no reset to 0), which gives a click-free retrigger.
- On note_off:
  - gate ← 0.
  - State ATTACK/DECAY/SUSTAIN → RELEASE; env_level is retained.
  - In IDLE or RELEASE, the state is unchanged.
- Tick generator:
  - Free-running counter from 0 to DIV−1.
  - tick = 1 for exactly the one cycle in which the count equals DIV−1; the counter then wraps to 0.
- State machine (level changes only on tick cycles, and only when no event occurs in that cycle):
  - IDLE: env_level is held at 0.
  - ATTACK: sum = level + ATTACK_STEP, computed at 17 bits. If sum ≥ 16'hFFFF: level ← 16'hFFFF and state → DECAY. Otherwise level ← sum.
  - DECAY: if level ≤ SUSTAIN_LEVEL + DECAY_STEP (17-bit compare): level ← SUSTAIN_LEVEL and state → SUSTAIN. Otherwise level ← level − DECAY_STEP.
  - SUSTAIN: level is held.
  - RELEASE: if level ≤ RELEASE_STEP: level ← 0 and state → IDLE. Otherwise level ← level − RELEASE_STEP.
- Priority: an event in the same cycle as a tick wins. The state transitions and that tick's level update is skipped.
- amp_out: the 23-bit product env_level × vel_lat shifted right by 7. The result always fits in 16 bits because vel_lat ≤ 127.
- Steps of 0 are legal: the level then never moves in that state.

## Timing
- Input change sampled at edge N → note_out, gate and env_state updated at edge N+1.
- Tick at edge T → env_level updated at T; env_state transition is visible at T.
- amp_out lags env_level by exactly 1 cycle.
- Reset mid-envelope: all outputs are 0 at the reset edge and there is no residual release. After reset the first detected event needs prev_vel = 0, so a key already held through reset produces a note_on one cycle after reset deasserts.
- Upstream holds its values, so no handshake is required; the inputs are assumed to be in the clk_50m domain.

## Test plan
- Use CLK_HZ=100 and TICK_HZ=10 (DIV=10), with ATTACK 0x4000, DECAY 0x1000, SUSTAIN 0xC000, RELEASE 0x2000.
- Note-on note=60, vel=100:
  - Next cycle: note_out=60, gate=1, state=1.
  - Ticks give levels 4000, 8000, C000, FFFF, then state=2.
  - amp_out reads 0xC7FF one cycle after FFFF.
- Decay from FFFF: EFFF, DFFF, CFFF, then C000 with state=3. amp_out reaches 0x9600.
- Note-off (velocity→0) in SUSTAIN:
  - gate=0 and state=4 next cycle.
  - Levels A000, 8000, 6000, 4000, 2000, then 0 with state=0.
- Retrigger:
  - Note change 60→64 with vel=100 during RELEASE at level 6000 → state=1, level stays 6000, note_out=64.
  - Next tick gives A000.
- Event on the same cycle as a tick: note_off lands at count=DIV−1 in ATTACK at 8000 → state=4, level stays 8000 (tick skipped). Assert rst_n=0 mid-RELEASE → all outputs 0 on the next edge.
